// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single regfile write port between EXU (req0)
// and LSU (req1) write-back traffic. Each requester owns a one-entry buffer
// with a valid/ready handshake; a round-robin arbiter drains one buffer per
// cycle onto rw_en/rw_addr/rw_data.
// Ports: clk, rst_n (async, active-low),
//   req0_valid/req0_ready/req0_addr/req0_data  EXU write-back
//   req1_valid/req1_ready/req1_addr/req1_data  LSU write-back
//   rw_en/rw_addr/rw_data                      regfile write port
//   grant                                      buffer driven this cycle
// Optional macro WB_ARB_FWD_EN adds fwd_addr/fwd_hit/fwd_data, a lookup of
// pending writes so readers can bypass the regfile.
module wb_port_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
`ifdef WB_ARB_FWD_EN
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              rw_en,
    output logic [ADDR_W-1:0] rw_addr,
    output logic [DATA_W-1:0] rw_data,
    output logic              grant
);

    logic              full0, full1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    logic              rr_ptr;
    // index of the older buffer when both are full
    logic              age;

    logic drain0, drain1;
    logic store0, store1;
    logic keep0, keep1;

    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            full0 & full1:  grant = rr_ptr;
            full1 & ~full0: grant = 1'b1;
            default:        grant = 1'b0;
        endcase
    end

    always_comb begin
        rw_en   = full0 | full1;
        rw_addr = '0;
        rw_data = '0;
        if (rw_en) begin
            rw_addr = grant ? addr1 : addr0;
            rw_data = grant ? data1 : data0;
        end
    end

    assign drain0 = rw_en & ~grant;
    assign drain1 = rw_en & grant;

    assign req0_ready = ~full0 | drain0;
    assign req1_ready = ~full1 | drain1;

    // writes to x0 complete the handshake but are dropped here
    assign store0 = req0_valid & req0_ready & (req0_addr != '0);
    assign store1 = req1_valid & req1_ready & (req1_addr != '0);

    // buffer still holding its old entry after this edge
    assign keep0 = full0 & ~drain0;
    assign keep1 = full1 & ~drain1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full0  <= 1'b0;
            full1  <= 1'b0;
            addr0  <= '0;
            addr1  <= '0;
            data0  <= '0;
            data1  <= '0;
            rr_ptr <= 1'b0;
            age    <= 1'b0;
        end else begin
            if (store0) begin
                full0 <= 1'b1;
                addr0 <= req0_addr;
                data0 <= req0_data;
            end else if (drain0) begin
                full0 <= 1'b0;
            end
            if (store1) begin
                full1 <= 1'b1;
                addr1 <= req1_addr;
                data1 <= req1_data;
            end else if (drain1) begin
                full1 <= 1'b0;
            end
            if (full0 & full1) begin
                rr_ptr <= ~grant;
            end
            if (store0 & store1) begin
                age <= 1'b0;
            end else if (store0 & keep1) begin
                age <= 1'b1;
            end else if (store1 & keep0) begin
                age <= 1'b0;
            end
        end
    end

`ifdef WB_ARB_FWD_EN
    logic hit0, hit1;

    assign hit0 = full0 & (addr0 == fwd_addr) & (fwd_addr != '0);
    assign hit1 = full1 & (addr1 == fwd_addr) & (fwd_addr != '0);

    always_comb begin
        fwd_hit  = hit0 | hit1;
        fwd_data = '0;
        if (hit0 & hit1) begin
            // the younger entry is the later program-order write
            fwd_data = age ? data0 : data1;
        end else if (hit1) begin
            fwd_data = data1;
        end else if (hit0) begin
            fwd_data = data0;
        end
    end
`endif

endmodule
